// File: rtl/note_scheduler_if.sv
// note_scheduler_if: request inputs and tone/LED outputs of the
// note sequencer, grouped for the scheduler and its driver.
interface note_scheduler_if #(
    parameter int QW = 3
);
    logic [7:0]    rxData;
    logic          rxValid;
    logic [3:0]    btnPulse;
    logic [17:0]   toneHalfPeriod;
    logic          toneEn;
    logic [11:0]   ledNote;
    logic          busy;
    logic [QW-1:0] queueLevel;
    logic          dropped;

    modport master (
        output rxData, rxValid, btnPulse,
        input  toneHalfPeriod, toneEn, ledNote,
        input  busy, queueLevel, dropped
    );

    modport slave (
        input  rxData, rxValid, btnPulse,
        output toneHalfPeriod, toneEn, ledNote,
        output busy, queueLevel, dropped
    );
endinterface

// File: rtl/note_scheduler.sv
// note_scheduler: maps UART keys / buttons to notes, queues them
// and plays them one at a time with a silent gap in between.
module note_scheduler #(
    parameter int  C_SYSCLK_FRQ  = 100_000_000,
    parameter real C_MUSIC       = 5.0,
    parameter int  C_GAP_CYCLES  = 1000,
    parameter int  C_QUEUE_DEPTH = 4
) (
    input  logic              sysClk,
    input  logic              sysRst,
    note_scheduler_if.slave   bus
);
    localparam int AW = $clog2(C_QUEUE_DEPTH);
    localparam int QW = AW + 1;
    localparam int D_CYC =
        $rtoi(real'(C_SYSCLK_FRQ) * C_MUSIC / 1000.0 + 0.5);
    localparam int CMAX =
        (D_CYC > C_GAP_CYCLES) ? D_CYC : C_GAP_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] D_LOAD = CW'(D_CYC - 1);
    localparam logic [CW-1:0] G_LOAD = CW'(C_GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    function automatic logic [12*18-1:0] hp_table();
        logic [12*18-1:0] t;
        real f;
        t = '0;
        for (int i = 0; i < 12; i++) begin
            f = 261.6256 * (2.0 ** (real'(i) / 12.0));
            t[i*18 +: 18] =
                18'($rtoi(real'(C_SYSCLK_FRQ) / (2.0 * f) + 0.5));
        end
        return t;
    endfunction

    localparam logic [12*18-1:0] HP_TAB = hp_table();

    logic          key_hit;
    logic [3:0]    key_idx;
    logic [3:0]    btn_idx;
    logic          stop, key_req, btn_req;
    logic          win_valid, lost, push, pop, full, drop;
    logic [3:0]    win_idx, head;

    logic [3:0]    mem_q [C_QUEUE_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [QW-1:0] cnt_q;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [17:0]   hp_q, hp_d;
    logic          en_q, en_d;
    logic [11:0]   led_q, led_d;
    logic          busy_q, drop_q;

    // ASCII key to note index
    always_comb begin
        key_hit = 1'b1;
        key_idx = 4'd0;
        case (bus.rxData)
            8'h7A:   key_idx = 4'd0;
            8'h73:   key_idx = 4'd1;
            8'h78:   key_idx = 4'd2;
            8'h64:   key_idx = 4'd3;
            8'h63:   key_idx = 4'd4;
            8'h76:   key_idx = 4'd5;
            8'h67:   key_idx = 4'd6;
            8'h62:   key_idx = 4'd7;
            8'h68:   key_idx = 4'd8;
            8'h6E:   key_idx = 4'd9;
            8'h6A:   key_idx = 4'd10;
            8'h6D:   key_idx = 4'd11;
            default: key_hit = 1'b0;
        endcase
    end

    // lowest pressed button wins
    always_comb begin
        btn_idx = 4'd0;
        if (bus.btnPulse[0])      btn_idx = 4'd0;
        else if (bus.btnPulse[1]) btn_idx = 4'd4;
        else if (bus.btnPulse[2]) btn_idx = 4'd7;
        else if (bus.btnPulse[3]) btn_idx = 4'd11;
    end

    assign stop    = bus.rxValid && (bus.rxData == 8'hFF);
    assign key_req = bus.rxValid && key_hit;
    assign btn_req = |bus.btnPulse;

    assign win_valid = !stop && (btn_req || key_req);
    assign win_idx   = btn_req ? btn_idx : key_idx;
    assign lost      = btn_req && (stop || key_req);

    assign full = (cnt_q == QW'(C_QUEUE_DEPTH));
    assign pop  = !stop && (state_q == S_IDLE) && (cnt_q != '0);
    assign push = win_valid && (!full || pop);
    assign drop = lost || (win_valid && !push);
    assign head = mem_q[rd_q];

    // queue storage, no reset needed
    always_ff @(posedge sysClk) begin
        if (push) mem_q[wr_q] <= win_idx;
    end

    // queue pointers and occupancy; STOP flushes
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (stop) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // play/gap sequencer next state
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        hp_d    = hp_q;
        en_d    = en_q;
        led_d   = led_q;
        if (stop) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            led_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (pop) begin
                    hp_d    = HP_TAB[int'(head)*18 +: 18];
                    en_d    = 1'b1;
                    led_d   = 12'b1 << head;
                    tmr_d   = D_LOAD;
                    state_d = S_PLAY;
                end
                S_PLAY: if (tmr_q == '0) begin
                    en_d    = 1'b0;
                    led_d   = '0;
                    tmr_d   = G_LOAD;
                    state_d = S_GAP;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
                S_GAP: if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // sequencer and output registers
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            hp_q    <= '0;
            en_q    <= 1'b0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            hp_q    <= hp_d;
            en_q    <= en_d;
            led_q   <= led_d;
            busy_q  <= (state_d != S_IDLE);
            drop_q  <= drop;
        end
    end

    assign bus.toneHalfPeriod = hp_q;
    assign bus.toneEn         = en_q;
    assign bus.ledNote        = led_q;
    assign bus.busy           = busy_q;
    assign bus.queueLevel     = cnt_q;
    assign bus.dropped        = drop_q;
endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: vector table, timing sequences and a random
// run against a queue/timeline model of the note scheduler.
module tb_note_scheduler;
    localparam int D   = 20;
    localparam int G   = 5;
    localparam int DEP = 4;
    localparam int QW  = 3;

    logic sysClk = 1'b0;
    logic sysRst = 1'b1;
    always #5 sysClk = ~sysClk;

    note_scheduler_if #(.QW(QW)) bus ();

    note_scheduler #(
        .C_SYSCLK_FRQ (100_000_000),
        .C_MUSIC      (0.0002),
        .C_GAP_CYCLES (G),
        .C_QUEUE_DEPTH(DEP)
    ) dut (
        .sysClk(sysClk),
        .sysRst(sysRst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endfunction

    function automatic int hp_ref(int i);
        real f;
        f = 261.6256 * (2.0 ** (i / 12.0));
        return $rtoi(100000000.0 / (2.0 * f) + 0.5);
    endfunction

    // ---- reference model: note queue + play timeline ----
    string keys = "zsxdcvgbhnjm";
    int    m_t, m_free, m_start, m_cur, m_hp;
    bit    m_act, m_drp;
    int    m_q[$];

    function automatic void mdl_reset();
        m_q.delete();
        m_t = 0; m_free = 0; m_act = 0;
        m_hp = 0; m_drp = 0; m_cur = 0; m_start = 0;
    endfunction

    function automatic void mdl_edge(logic v, logic [7:0] d,
                                     logic [3:0] b);
        int kidx, bidx, nb, widx;
        bit key, pop, bp;
        m_t++;
        bp = (b != 0);
        kidx = -1;
        for (int i = 0; i < 12; i++)
            if (v && keys[i] == d) kidx = i;
        key = (kidx >= 0);
        bidx = b[0] ? 0 : b[1] ? 4 : b[2] ? 7 : 11;
        m_drp = 0;
        if (v && d == 8'hFF) begin
            m_q.delete();
            m_act = 0;
            m_free = m_t + 1;
            m_drp = bp;
            return;
        end
        nb = m_q.size();
        pop = (m_t >= m_free) && (nb > 0);
        widx = bp ? bidx : kidx;
        m_drp = bp && key;
        if (pop) begin
            m_cur = m_q.pop_front();
            m_act = 1;
            m_start = m_t;
            m_hp = hp_ref(m_cur);
            m_free = m_t + D + G + 1;
        end
        if (bp || key) begin
            if (nb < DEP || pop) m_q.push_back(widx);
            else m_drp = 1;
        end
    endfunction

    task automatic mchk();
        bit en, bz;
        en = m_act && (m_t < m_start + D);
        bz = m_act && (m_t < m_start + D + G);
        chk("rnd_en", int'(bus.toneEn), int'(en));
        chk("rnd_busy", int'(bus.busy), int'(bz));
        chk("rnd_led", int'(bus.ledNote),
            en ? (1 << m_cur) : 0);
        chk("rnd_hp", int'(bus.toneHalfPeriod), m_hp);
        chk("rnd_lvl", int'(bus.queueLevel), m_q.size());
        chk("rnd_drop", int'(bus.dropped), int'(m_drp));
    endtask

    // one clock: drive at negedge, edge, return at next negedge
    task automatic cyc(input logic v, input logic [7:0] d,
                       input logic [3:0] b);
        bus.rxValid  = v;
        bus.rxData   = d;
        bus.btnPulse = b;
        @(posedge sysClk);
        mdl_edge(v, d, b);
        @(negedge sysClk);
        bus.rxValid  = 1'b0;
        bus.btnPulse = 4'h0;
    endtask

    task automatic idle(); cyc(1'b0, 8'h00, 4'h0); endtask

    task automatic do_reset();
        sysRst = 1'b1;
        mdl_reset();
        @(negedge sysClk);
        @(negedge sysClk);
        sysRst = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [3:0] b;
        int         idx;
        int         hp;
        logic       drop;
    } vec_t;

    vec_t tab[11];

    initial begin
        int n, k;
        bit low;
        tab[0]  = '{1'b1, 8'h7A, 4'h0, 0, 191113, 1'b0};
        tab[1]  = '{1'b1, 8'h67, 4'h0, 6, 135137, 1'b0};
        tab[2]  = '{1'b1, 8'h6E, 4'h0, 9, 113636, 1'b0};
        tab[3]  = '{1'b1, 8'h6D, 4'h0, 11, 0, 1'b0};
        tab[4]  = '{1'b0, 8'h00, 4'h1, 0, 191113, 1'b0};
        tab[5]  = '{1'b0, 8'h00, 4'h8, 11, 0, 1'b0};
        tab[6]  = '{1'b1, 8'h6E, 4'h6, 4, 0, 1'b1};
        tab[7]  = '{1'b1, 8'h41, 4'h0, -1, 0, 1'b0};
        tab[8]  = '{1'b0, 8'h00, 4'hC, 7, 0, 1'b0};
        tab[9]  = '{1'b1, 8'hFF, 4'h4, -1, 0, 1'b1};
        tab[10] = '{1'b1, 8'h73, 4'h0, 1, 0, 1'b0};

        bus.rxValid  = 1'b0;
        bus.rxData   = 8'h00;
        bus.btnPulse = 4'h0;
        do_reset();

        chk("rst_hp", int'(bus.toneHalfPeriod), 0);
        chk("rst_en", int'(bus.toneEn), 0);
        chk("rst_led", int'(bus.ledNote), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_lvl", int'(bus.queueLevel), 0);
        chk("rst_drop", int'(bus.dropped), 0);

        // single note: latency, duration, gap
        cyc(1'b1, 8'h7A, 4'h0);
        chk("z_lvl_push", int'(bus.queueLevel), 1);
        chk("z_en_early", int'(bus.toneEn), 0);
        idle();
        chk("z_en", int'(bus.toneEn), 1);
        chk("z_led", int'(bus.ledNote), 1);
        chk("z_hp", int'(bus.toneHalfPeriod), 191113);
        chk("z_lvl_pop", int'(bus.queueLevel), 0);
        chk("z_busy", int'(bus.busy), 1);
        n = 1;
        while (bus.toneEn && n < D + 10) begin
            idle();
            if (bus.toneEn) n++;
        end
        chk("z_play_len", n, D);
        chk("z_led_off", int'(bus.ledNote), 0);
        chk("z_hp_keep", int'(bus.toneHalfPeriod), 191113);
        k = 0;
        while (bus.busy && k < G + 10) begin
            idle();
            k++;
        end
        chk("z_gap_len", k, G);

        // back-to-back notes
        do_reset();
        cyc(1'b1, 8'h7A, 4'h0);
        cyc(1'b1, 8'h67, 4'h0);
        k = 0;
        low = 0;
        while (k < D + G + 20) begin
            idle();
            k++;
            if (!bus.toneEn) low = 1;
            else if (low) break;
        end
        chk("zg_rise_gap", k, D + G + 1);
        chk("zg_led", int'(bus.ledNote), 'h040);
        chk("zg_hp", int'(bus.toneHalfPeriod), 135137);

        // STOP mid-note with a queued note
        do_reset();
        cyc(1'b1, 8'h7A, 4'h0);
        cyc(1'b1, 8'h67, 4'h0);
        idle();
        idle();
        cyc(1'b1, 8'hFF, 4'h0);
        chk("stop_en", int'(bus.toneEn), 0);
        chk("stop_led", int'(bus.ledNote), 0);
        chk("stop_lvl", int'(bus.queueLevel), 0);
        chk("stop_busy", int'(bus.busy), 0);
        n = 0;
        for (int i = 0; i < D + G + 5; i++) begin
            idle();
            if (bus.toneEn) n++;
        end
        chk("stop_silent", n, 0);

        // overfill while playing
        do_reset();
        cyc(1'b1, 8'h7A, 4'h0);
        idle();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'h78, 4'h0);
            chk($sformatf("full%0d_drop", i),
                int'(bus.dropped), (i == 4) ? 1 : 0);
            chk($sformatf("full%0d_lvl", i),
                int'(bus.queueLevel), (i < 4) ? i + 1 : 4);
        end
        idle();
        chk("full_drop_clr", int'(bus.dropped), 0);

        // vector table
        for (int i = 0; i < 11; i++) begin
            cyc(1'b1, 8'hFF, 4'h0);
            cyc(tab[i].v, tab[i].d, tab[i].b);
            chk($sformatf("tab%0d_drop", i),
                int'(bus.dropped), int'(tab[i].drop));
            idle();
            if (tab[i].idx >= 0) begin
                chk($sformatf("tab%0d_led", i),
                    int'(bus.ledNote), 1 << tab[i].idx);
                chk($sformatf("tab%0d_en", i),
                    int'(bus.toneEn), 1);
                chk($sformatf("tab%0d_hp", i),
                    int'(bus.toneHalfPeriod),
                    (tab[i].hp != 0) ? tab[i].hp
                                     : hp_ref(tab[i].idx));
            end else begin
                chk($sformatf("tab%0d_led", i),
                    int'(bus.ledNote), 0);
                chk($sformatf("tab%0d_en", i),
                    int'(bus.toneEn), 0);
            end
        end

        // asynchronous reset in the middle of PLAY
        do_reset();
        cyc(1'b1, 8'h7A, 4'h0);
        cyc(1'b1, 8'h67, 4'h0);
        idle();
        idle();
        #2 sysRst = 1'b1;
        #1;
        chk("arst_en", int'(bus.toneEn), 0);
        chk("arst_led", int'(bus.ledNote), 0);
        chk("arst_hp", int'(bus.toneHalfPeriod), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_lvl", int'(bus.queueLevel), 0);
        chk("arst_drop", int'(bus.dropped), 0);
        mdl_reset();
        @(negedge sysClk);
        sysRst = 1'b0;
        idle();
        chk("arst_lvl_after", int'(bus.queueLevel), 0);
        chk("arst_en_after", int'(bus.toneEn), 0);

        // random run against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic       v;
            logic [7:0] d;
            logic [3:0] b;
            int         r;
            v = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 199);
            if (r < 2)       d = 8'hFF;
            else if (r < 150) d = keys[$urandom_range(0, 11)];
            else             d = 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0)
                ? 4'($urandom_range(1, 15)) : 4'h0;
            cyc(v, d, b);
            mchk();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/note_scheduler.md
# note_scheduler

Sequencer between the UART receiver / button debouncers and the tone generator of the music keyboard. It maps received ASCII keys and debounced button pulses to one of 12 notes (C4..B4) and queues them in a small FIFO. Notes are played one at a time, each for a fixed duration followed by a silent gap. It drives the tone generator's half-period configuration and enable, plus the 12-bit one-hot note pattern for the RGB LEDs.

## Interface

- C_SYSCLK_FRQ, 100_000_000, system clock frequency [Hz].
- C_MUSIC, 5.0, note duration [ms]; duration cycles D = round(C_SYSCLK_FRQ*C_MUSIC/1000), 500_000 by default.
- C_GAP_CYCLES, 1000, silent cycles between consecutive notes (≥1).
- C_QUEUE_DEPTH, 4, FIFO depth in notes (power of 2, ≥2).

Ports:

- sysClk  in  1  system clock. One clock domain.
- sysRst  in  1  reset, asynchronous, active-high.
- rxData  in  8  byte from the UART receiver.
- rxValid  in  1  one-cycle strobe; rxData is valid in that cycle.
- btnPulse  in  4  debounced one-cycle press pulses.
- toneHalfPeriod  out  18  half-period in sysClk cycles for the tone generator.
- toneEn  out  1  tone generator enable.
- ledNote  out  12  one-hot note pattern, bit = note index; 0 when silent.
- busy  out  1  high in PLAY or GAP.
- queueLevel  out  $clog2(C_QUEUE_DEPTH)+1  FIFO occupancy.
- dropped  out  1  one-cycle pulse when a request is discarded.

## Operation

- Key map (ASCII → index): z0 s1 x2 d3 c4 v5 g6 b7 h8 n9 j10 m11. Any other byte is ignored (no drop pulse), except 0xFF.
- Buttons map as follows: btnPulse[0]→0 (C), [1]→4 (E), [2]→7 (G), [3]→11 (B). When several bits are set, the lowest set bit wins and the others are ignored.
- Half-period table: the entry for index i is round(C_SYSCLK_FRQ/(2·f_i)), with f_i = 261.6256·2^(i/12) Hz. It is computed at elaboration. Defaults: C 191113, F# 135137, A 113636.
- Request arbitration, one FIFO write per cycle. Priority order:
  - 0xFF (STOP) has the highest priority.
  - A button request comes next.
  - A mapped UART key comes last.
  - A valid request that loses arbitration is discarded and pulses dropped.
- STOP:
  - Empties the FIFO.
  - Aborts any note in progress.
  - The FSM goes to IDLE at the same edge.
  - toneEn and ledNote are 0 in the following cycle.
- FIFO full:
  - A push is accepted if a pop happens in the same cycle.
  - Otherwise the request is discarded and dropped pulses.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop it, load toneHalfPeriod, set toneEn=1 and ledNote=1<<idx, load the counter with D−1, and go to PLAY.
  - PLAY: decrement the counter. When it reaches 0, set toneEn=0 and ledNote=0, load the counter with C_GAP_CYCLES−1, and go to GAP.
  - GAP: decrement the counter. When it reaches 0, go to IDLE.
- toneHalfPeriod keeps its last value while silent.
- Reset values: FSM IDLE, FIFO empty, toneHalfPeriod 0, toneEn 0, ledNote 0, busy 0, queueLevel 0, dropped 0.
- Reset is asserted asynchronously and released synchronously to sysClk by the existing reset logic. No separate synchronizer is needed here.

## Timing

- All outputs are registered.
- Latency from an idle, empty state: a request sampled at edge N is written at N. The FSM pops at N+1. toneEn and ledNote are high from edge N+1, i.e. one cycle after the request edge.
- toneEn stays high for exactly D cycles.
- Consecutive notes: the next toneEn rise is exactly D + C_GAP_CYCLES + 1 cycles after the previous rise (the extra cycle is the IDLE pop).
- queueLevel reflects pushes and pops of edge N from edge N onward.
- dropped is high for exactly the cycle after the discarding edge.

## Test plan

- Reset, then 'z' (0x7A) via rxValid: toneEn rises 1 clock later; toneHalfPeriod=191113 and ledNote=0x001 for 500_000 cycles; then silence; busy falls after 1000 more cycles.
- 'z' then 'g' (0x67) back-to-back: the second note starts 501_001 cycles after the first; ledNote=0x040, toneHalfPeriod=135137.
- 0xFF mid-note: toneEn=0, ledNote=0 and queueLevel=0 one cycle after the strobe; a queued note never plays.
- While playing, push 5 notes into the depth-4 FIFO: the 5th push gives one dropped pulse and queueLevel stays 4.
- rxValid('n') and btnPulse=4'b0110 in the same cycle: only E (index 4) is enqueued and one dropped pulse occurs; 0x41 ('A') is ignored with no pulse.
- Assert sysRst in the middle of PLAY: all outputs return to their reset values immediately without waiting for a clock edge; the FIFO is empty afterwards.
